// File: rtl/shiftout_pkg.sv
// Shared types and constants for the TDC serial readout sequencer.
package shiftout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_ID,
    ST_DATA,
    ST_GAP
  } state_t;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEF_ID_W   = 2;
  localparam int unsigned FRAME_BITS = 1 + DEF_ID_W + DATA_W;
  localparam logic        START_BIT  = 1'b1;

  // Frame length in bits for an arbitrary source-ID width.
  function automatic int unsigned frame_bits(input int unsigned id_w);
    return 1 + id_w + DATA_W;
  endfunction

  // Source-ID width required for n requesters: max(1, clog2(n)).
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shiftout_sreg.sv
// Parallel-load, MSB-first shift register holding {source ID, data word}.
module shiftout_sreg
  import shiftout_pkg::*;
#(
  parameter int W = DATA_W + DEF_ID_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Load has priority over shift; zeros fill from the LSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sr <= '0;
    else if (ld)    sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/shiftout_rr_sequencer.sv
// Round-robin readout sequencer: grants one requester at a time and
// serialises start bit, source ID and 32-bit hit word MSB first.
module shiftout_rr_sequencer
  import shiftout_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int DIV   = 2,
  parameter int GAP   = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  sdata,
  output logic                  sframe,
  output logic                  busy,
  output logic [CNT_W-1:0]      frames_sent
);

  localparam int unsigned SR_W   = frame_bits(ID_W) - 1;
  localparam logic [7:0]  DIV_M1 = 8'(DIV - 1);
  localparam logic [7:0]  GAP_M1 = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("shiftout_rr_sequencer: N_REQ must be 2..16");
  end
  if (ID_W != int'(id_width(N_REQ))) begin : g_bad_idw
    $error("shiftout_rr_sequencer: ID_W must equal max(1, clog2(N_REQ))");
  end
  if (DIV < 1 || DIV > 255) begin : g_bad_div
    $error("shiftout_rr_sequencer: DIV must be 1..255");
  end
  if (GAP < 0 || GAP > 255) begin : g_bad_gap
    $error("shiftout_rr_sequencer: GAP must be 0..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("shiftout_rr_sequencer: CNT_W must be at least 1");
  end

  state_t            state, state_nx;
  logic [7:0]        tmr, tmr_nx;
  logic [4:0]        bidx, bidx_nx;
  logic [ID_W-1:0]   last, last_nx;
  logic [ID_W-1:0]   gnt, gnt_nx;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic              cnt_inc;
  logic              sr_ld, sr_shift, sr_msb;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[32*i +: 32];
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    logic [ID_W-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((32'(last) + off) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state logic: bit-timer, bit-index counter and frame sequencing.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    bidx_nx  = bidx;
    last_nx  = last;
    gnt_nx   = gnt;
    sr_ld    = 1'b0;
    sr_shift = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && found) begin
          gnt_nx   = pick;
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_ld    = 1'b1;
        last_nx  = gnt;
        tmr_nx   = DIV_M1;
        state_nx = ST_START;
      end
      ST_START: begin
        if (tmr == 8'd0) begin
          tmr_nx   = DIV_M1;
          bidx_nx  = 5'(ID_W - 1);
          state_nx = ST_ID;
        end else begin
          tmr_nx = tmr - 8'd1;
        end
      end
      ST_ID: begin
        if (tmr == 8'd0) begin
          tmr_nx   = DIV_M1;
          sr_shift = 1'b1;
          if (bidx == 5'd0) begin
            bidx_nx  = 5'd31;
            state_nx = ST_DATA;
          end else begin
            bidx_nx = bidx - 5'd1;
          end
        end else begin
          tmr_nx = tmr - 8'd1;
        end
      end
      ST_DATA: begin
        if (tmr == 8'd0) begin
          tmr_nx   = DIV_M1;
          sr_shift = 1'b1;
          if (bidx == 5'd0) begin
            cnt_inc = 1'b1;
            if (GAP == 0) begin
              state_nx = ST_IDLE;
            end else begin
              tmr_nx   = GAP_M1;
              state_nx = ST_GAP;
            end
          end else begin
            bidx_nx = bidx - 5'd1;
          end
        end else begin
          tmr_nx = tmr - 8'd1;
        end
      end
      ST_GAP: begin
        if (tmr == 8'd0) state_nx = ST_IDLE;
        else             tmr_nx   = tmr - 8'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counters, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tmr   <= '0;
      bidx  <= '0;
      gnt   <= '0;
      last  <= ID_W'(N_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      bidx  <= bidx_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

  shiftout_sreg #(
    .W (SR_W)
  ) u_sreg (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (sr_ld),
    .shift (sr_shift),
    .din   ({gnt, words[gnt]}),
    .msb   (sr_msb)
  );

  // Output decode from registered state; all outputs are 0 in reset/IDLE.
  always_comb begin
    sdata     = 1'b0;
    sframe    = 1'b0;
    req_ready = '0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_LOAD:         req_ready[gnt] = 1'b1;
      ST_START: begin
        sframe = 1'b1;
        sdata  = START_BIT;
      end
      ST_ID, ST_DATA: begin
        sframe = 1'b1;
        sdata  = sr_msb;
      end
      default: ;
    endcase
  end

  assign frames_sent = cnt;

endmodule

// File: tb/tb_shiftout_rr_sequencer.sv
// Self-checking bench for shiftout_rr_sequencer against a queue-based model.
module tb_shiftout_rr_sequencer;
  import shiftout_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int DIV   = 2;
  localparam int GAP   = 4;
  localparam int CNT_W = 4;
  localparam int FCLK  = FRAME_BITS * DIV;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 enable = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [32*N_REQ-1:0]  req_data = '0;
  logic [N_REQ-1:0]     req_ready;
  logic                 sdata, sframe, busy;
  logic [CNT_W-1:0]     frames_sent;

  shiftout_rr_sequencer #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W),
    .DIV   (DIV),
    .GAP   (GAP),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .sdata       (sdata),
    .sframe      (sframe),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int m_last;
  int m_cnt;
  int last_grant;
  logic [31:0] q [N_REQ][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] mask);
    for (int off = 1; off <= N_REQ; off++) begin
      if (mask[(last + off) % N_REQ]) return (last + off) % N_REQ;
    end
    return -1;
  endfunction

  // Bit k of a frame: start bit, ID MSB first, then data bit 31..0.
  function automatic logic frame_bit(input int id, input logic [31:0] d, input int k);
    if (k == 0) return START_BIT;
    if (k <= ID_W) return id[ID_W - k];
    return d[31 - (k - 1 - ID_W)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = (q[i].size() > 0);
      req_data[32*i +: 32] = (q[i].size() > 0) ? q[i][0] : 32'h0;
    end
  endtask

  task automatic model_reset();
    m_last     = N_REQ - 1;
    m_cnt      = 0;
    last_grant = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  // Waits for the predicted grant and checks the whole frame plus GAP.
  task automatic serve(input int max_wait, input int en_drop_k, input int abort_k, input bit spacing);
    logic [N_REQ-1:0] mask;
    logic [31:0]      w;
    int               g;
    for (int i = 0; i < N_REQ; i++) mask[i] = (q[i].size() > 0);
    g = rr_pick(m_last, mask);
    if (g < 0) return;
    w = q[g][0];
    for (int i = 0; i < max_wait; i++) begin
      tick();
      if (req_ready != '0) break;
    end
    check("grant", 64'(req_ready), 64'(1) << g);
    if (spacing && last_grant >= 0) check("spacing", 64'(cyc - last_grant), 64'(GAP + 2 + FCLK));
    last_grant = cyc;
    for (int k = 0; k < FCLK; k++) begin
      tick();
      if (k == 0) begin
        void'(q[g].pop_front());
        drive_inputs();
        check("ready_pulse", 64'(req_ready), 64'(0));
      end
      if (k == en_drop_k) enable = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_sdata", 64'(sdata), 64'(0));
        check("rst_sframe", 64'(sframe), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_count", 64'(frames_sent), 64'(0));
        model_reset();
        return;
      end
      check($sformatf("sframe[%0d]", k), 64'(sframe), 64'(1));
      check($sformatf("sdata[%0d]", k), 64'(sdata), 64'(frame_bit(g, w, k / DIV)));
      check("busy_frame", 64'(busy), 64'(1));
      check("count_frame", 64'(frames_sent), 64'(m_cnt));
    end
    m_last = g;
    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    for (int j = 0; j < GAP; j++) begin
      tick();
      check("gap_sframe", 64'(sframe), 64'(0));
      check("gap_sdata", 64'(sdata), 64'(0));
      check("gap_busy", 64'(busy), 64'(1));
      check("count_gap", 64'(frames_sent), 64'(m_cnt));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_sdata", 64'(sdata), 64'(0));
    check("reset_sframe", 64'(sframe), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_count", 64'(frames_sent), 64'(0));
    tick();
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;

    // Single requester 2 with a known word.
    q[2].push_back(32'hA500_0001);
    drive_inputs();
    serve(20, -1, -1, 1'b0);
    check("single_count", 64'(frames_sent), 64'(1));
    tick();
    check("single_idle_busy", 64'(busy), 64'(0));
    check("single_idle_ready", 64'(req_ready), 64'(0));

    // Fairness after reset: all four held.
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      q[i].push_back($urandom());
      q[i].push_back($urandom());
    end
    drive_inputs();
    for (int f = 0; f < 6; f++) serve(20, -1, -1, 1'b1);
    q[2].delete();
    q[3].delete();
    drive_inputs();

    // All-ones then all-zeros data from requester 1.
    q[1].push_back(32'hFFFF_FFFF);
    q[1].push_back(32'h0000_0000);
    drive_inputs();
    serve(20, -1, -1, 1'b0);
    serve(20, -1, -1, 1'b1);

    // Reset in the middle of DATA, then requester 1 wins first.
    q[2].push_back($urandom());
    drive_inputs();
    serve(20, -1, 2 * (1 + ID_W + 10), 1'b0);
    #4 rst_n = 1'b1;
    q[1].push_back($urandom());
    q[2].push_back($urandom());
    drive_inputs();
    serve(20, -1, -1, 1'b0);

    // Enable dropped during the ID field.
    serve(20, 3, -1, 1'b0);
    q[3].push_back($urandom());
    drive_inputs();
    tick();
    check("en_off_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("en_off_ready", 64'(req_ready), 64'(0));
      check("en_off_idle", 64'(busy), 64'(0));
    end
    enable = 1'b1;
    serve(1, -1, -1, 1'b0);

    // Random traffic with drop-outs; also carries the counter through its wrap.
    for (int f = 0; f < 20; f++) begin
      int n;
      int any;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) q[$urandom_range(0, N_REQ - 1)].push_back($urandom());
      if ($urandom_range(0, 3) == 0) q[$urandom_range(0, N_REQ - 1)].delete();
      any = 0;
      for (int i = 0; i < N_REQ; i++) any += q[i].size();
      if (any == 0) q[$urandom_range(0, N_REQ - 1)].push_back($urandom());
      drive_inputs();
      serve(20, -1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
